xor_stream_descrambler: RTL and testbench
=========================================

// Module: xor_stream_descrambler
// PURPOSE
//  Receive-side decoder for the XOR word-cipher link: XORs each incoming 32-bit
//  word with a keystream from a Galois LFSR that matches the transmit-side scrambler.
//  Sits between the peripheral input port and the miniRISC load path.
//  Valid/ready handshake on both sides; one output register; a seed command
//  resynchronises the keystream.
// PARAMETERS
//  WIDTH  32            data and keystream width
//  POLY   32'h04C11DB7  Galois LFSR feedback taps
//  SEED   32'hFFFFFFFF  keystream value after reset and on a zero-seed load
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  seed_load   in   1      one-cycle pulse: load seed_in and start decoding
//  seed_in     in   WIDTH  keystream seed
//  in_valid    in   1      in_data holds a scrambled word
//  in_data     in   WIDTH  scrambled word
//  in_ready    out  1      word accepted when in_valid && in_ready
//  out_valid   out  1      out_data holds a descrambled word
//  out_data    out  WIDTH  descrambled word
//  out_ready   in   1      sink accepts the word when out_valid && out_ready
//  busy        out  1      high in RUN state
//  word_count  out  16     words accepted since the last seed load; wraps at 16'hFFFF
// BEHAVIOUR
//  - Reset values: state=IDLE, ks=SEED, out_valid=0, out_data=0, word_count=0.
//    Because in_ready and busy are derived from state, both are 0 during reset.
//  - States:
//    - IDLE: no seed loaded yet; in_ready=0.
//    - RUN: decoding.
//    - IDLE->RUN on seed_load. RUN stays in RUN; a seed_load in RUN re-seeds.
//    - Only rst returns the block to IDLE.
//  - Seed load:
//    - ks <= (seed_in==0) ? SEED : seed_in. This prevents LFSR lock-up.
//    - out_valid <= 0 (a pending word is dropped), word_count <= 0.
//  - in_ready = (state==RUN) && !seed_load && (!out_valid || out_ready).
//    This is combinational. in_ready must not depend on in_valid.
//  - On an accepted word:
//    - out_data <= in_data ^ ks
//    - out_valid <= 1
//    - ks <= {ks[30:0],1'b0} ^ (ks[31] ? POLY : 0)
//    - word_count <= word_count+1
//  - Latency is 1 cycle from acceptance to out_valid.
//  - Throughput is 1 word per cycle while out_ready is held high.
//  - The keystream advances only on an accepted word. A stalled input does not consume keystream.
//  - out_valid && out_ready with no new acceptance -> out_valid <= 0.
//    Acceptance in the same cycle -> out_valid stays 1 with the new data.
//  - While out_valid && !out_ready: out_data is held stable and in_ready=0.
//  - seed_load has priority over the input handshake in the same cycle. That word is not accepted.
//  - rst asserted mid-stream: all state clears immediately. A seed_load is needed before decoding resumes.
// TESTING
//  1. rst, seed_load seed_in=FFFFFFFF, send 00000000 then 00000000, out_ready=1
//     -> out FFFFFFFF, then FB3EE249.
//  2. seed_in=00000001, send 12345678 then 00000000 -> out 12345679, then 00000002.
//     word_count=2.
//  3. seed_in=00000000 -> behaves as seed FFFFFFFF; repeat scenario 1 and expect identical outputs.
//  4. out_ready=0, offer A5A5A5A5 then 5A5A5A5A
//     -> after the first word: in_ready=0, out_data holds, ks does not advance.
//     Raise out_ready -> second word out = 5A5A5A5A ^ FB3EE249.
//  5. seed_load pulsed while out_valid=1 and in_valid=1 -> out_valid drops,
//     the word is not accepted, word_count=0, and the next word uses the new seed.
//  6. Scramble 1000 random words with a reference model of the same LFSR, feed them
//     with random valid/ready stalls -> every output equals its plaintext; rst
//     mid-run -> all outputs 0, in_ready=0.

Source files
------------

// File: rtl/xor_stream_descrambler_if.sv
// Stream bundle for the XOR descrambler: seed command, scrambled input and
// descrambled output handshakes. The descrambler uses the slave view.
interface xor_stream_descrambler_if #(
    parameter int WIDTH = 32
);
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output seed_load, seed_in, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  seed_load, seed_in, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/xor_stream_descrambler.sv
// Receive-side XOR word descrambler: each accepted word is XORed with a
// Galois LFSR keystream that mirrors the transmit-side scrambler.
module xor_stream_descrambler #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED  = 32'hFFFFFFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    xor_stream_descrambler_if.slave   bus,
    output logic                      busy,
    output logic [15:0]               word_count
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q,      state_d;
    logic [WIDTH-1:0] ks_q,         ks_d;
    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic [15:0]      word_count_q, word_count_d;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] ks_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ks_q         <= SEED;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ks_q         <= ks_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            word_count_q <= word_count_d;
        end
    end

    // A seed command wins over the input handshake, so the word offered in that
    // cycle is refused and decoding restarts from the fresh keystream.
    always_comb begin
        state_d      = state_q;
        ks_d         = ks_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        word_count_d = word_count_q;

        in_ready = (state_q == RUN) && !bus.seed_load && (!out_valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;
        ks_next  = {ks_q[WIDTH-2:0], 1'b0} ^ (ks_q[WIDTH-1] ? POLY : '0);

        if (bus.seed_load) begin
            state_d      = RUN;
            ks_d         = (bus.seed_in == '0) ? SEED : bus.seed_in;
            out_valid_d  = 1'b0;
            word_count_d = '0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                out_data_d   = bus.in_data ^ ks_q;
                out_valid_d  = 1'b1;
                ks_d         = ks_next;
                word_count_d = word_count_q + 16'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q == RUN);
    assign word_count    = word_count_q;

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Bench for xor_stream_descrambler: a transaction-level keystream model and a
// one-deep output queue predict every output; directed literals pin the model.
module tb_xor_stream_descrambler;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] word_count;

    xor_stream_descrambler_if #(.WIDTH(32)) bus ();

    xor_stream_descrambler #(.WIDTH(32), .POLY(POLY), .SEED(SEED)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Model state: decoding enabled, effective seed, words since seed,
    // outstanding output words, and the last word produced.
    bit          m_run  = 1'b0;
    logic [31:0] m_seed = SEED;
    int          m_cnt  = 0;
    logic [31:0] m_q[$];
    logic [31:0] m_od   = '0;

    function automatic logic [31:0] ks_at(logic [31:0] seed, int n);
        logic [31:0] k = seed;
        for (int i = 0; i < n; i++) begin
            k = (k << 1) ^ (k[31] ? POLY : 32'h0);
        end
        return k;
    endfunction

    function automatic bit exp_in_ready();
        return m_run && !bus.seed_load && (m_q.size() == 0 || bus.out_ready);
    endfunction

    task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %08h expected %08h", name, got, exp);
    endtask

    task automatic modelReset();
        m_run  = 1'b0;
        m_seed = SEED;
        m_cnt  = 0;
        m_q.delete();
        m_od   = '0;
    endtask

    // Advance one clock; the model consumes the inputs that were stable at the edge.
    task automatic tick();
        bit acc;
        @(posedge clk);
        if (rst) begin
            modelReset();
        end else begin
            acc = bus.in_valid && exp_in_ready();
            if (bus.seed_load) begin
                m_run  = 1'b1;
                m_seed = (bus.seed_in == 32'h0) ? SEED : bus.seed_in;
                m_cnt  = 0;
                m_q.delete();
            end else begin
                if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
                if (acc) begin
                    m_od = bus.in_data ^ ks_at(m_seed, m_cnt);
                    m_q.push_back(m_od);
                    m_cnt = (m_cnt + 1) & 16'hFFFF;
                end
            end
        end
        #1;
    endtask

    task automatic applyStimulus(bit valid, logic [31:0] data, bit ready);
        bus.in_valid  = valid;
        bus.in_data   = data;
        bus.out_ready = ready;
        tick();
    endtask

    task automatic sendSeed(logic [31:0] seed);
        bus.seed_load = 1'b1;
        bus.seed_in   = seed;
        tick();
        bus.seed_load = 1'b0;
    endtask

    always @(negedge clk) begin
        checkOutput("in_ready",   {31'h0, bus.in_ready},  {31'h0, exp_in_ready()});
        checkOutput("out_valid",  {31'h0, bus.out_valid}, {31'h0, (m_q.size() > 0)});
        checkOutput("out_data",   bus.out_data,           m_od);
        checkOutput("busy",       {31'h0, busy},          {31'h0, m_run});
        checkOutput("word_count", {16'h0, word_count},    m_cnt[31:0]);
    end

    logic [31:0] plain [1000];
    logic [31:0] cipher[1000];

    initial begin
        int idx;
        int out_idx;
        int cycles;
        bit acc;
        logic [31:0] k;

        bus.seed_load = 1'b0;
        bus.seed_in   = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        tick();
        tick();
        checkOutput("reset out_valid",  {31'h0, bus.out_valid}, 32'h0);
        checkOutput("reset in_ready",   {31'h0, bus.in_ready},  32'h0);
        checkOutput("reset busy",       {31'h0, busy},          32'h0);
        checkOutput("reset word_count", {16'h0, word_count},    32'h0);
        checkOutput("reset out_data",   bus.out_data,           32'h0);
        rst = 1'b0;

        // Scenario 1 and, with a zero seed, scenario 3 must give identical words.
        for (int pass = 0; pass < 2; pass++) begin
            bus.out_ready = 1'b1;
            sendSeed(pass == 0 ? 32'hFFFFFFFF : 32'h0);
            applyStimulus(1'b1, 32'h0, 1'b1);
            checkOutput("s1 word0", bus.out_data, 32'hFFFFFFFF);
            checkOutput("s1 model0", m_od, 32'hFFFFFFFF);
            applyStimulus(1'b1, 32'h0, 1'b1);
            checkOutput("s1 word1", bus.out_data, 32'hFB3EE249);
            checkOutput("s1 model1", m_od, 32'hFB3EE249);
            applyStimulus(1'b0, 32'h0, 1'b1);
        end

        sendSeed(32'h00000001);
        applyStimulus(1'b1, 32'h12345678, 1'b1);
        checkOutput("s2 word0", bus.out_data, 32'h12345679);
        applyStimulus(1'b1, 32'h00000000, 1'b1);
        checkOutput("s2 word1", bus.out_data, 32'h00000002);
        checkOutput("s2 word_count", {16'h0, word_count}, 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Back-pressure: the second word waits and must not consume keystream.
        sendSeed(32'hFFFFFFFF);
        applyStimulus(1'b1, 32'hA5A5A5A5, 1'b0);
        checkOutput("s4 word0", bus.out_data, 32'h5A5A5A5A);
        applyStimulus(1'b1, 32'h5A5A5A5A, 1'b0);
        applyStimulus(1'b1, 32'h5A5A5A5A, 1'b0);
        checkOutput("s4 stall in_ready", {31'h0, bus.in_ready}, 32'h0);
        checkOutput("s4 hold data", bus.out_data, 32'h5A5A5A5A);
        checkOutput("s4 hold count", {16'h0, word_count}, 32'd1);
        applyStimulus(1'b1, 32'h5A5A5A5A, 1'b1);
        checkOutput("s4 word1", bus.out_data, 32'hA164B813);
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Seed command collides with a pending output and an offered word.
        sendSeed(32'hFFFFFFFF);
        applyStimulus(1'b1, 32'h11111111, 1'b0);
        bus.in_data = 32'h22222222;
        sendSeed(32'h00000001);
        checkOutput("s5 out_valid", {31'h0, bus.out_valid}, 32'h0);
        checkOutput("s5 word_count", {16'h0, word_count}, 32'd0);
        applyStimulus(1'b1, 32'h12345678, 1'b1);
        checkOutput("s5 new seed", bus.out_data, 32'h12345679);
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Random stream scrambled with an independent running keystream.
        k = 32'h3C5A9E17;
        for (int i = 0; i < 1000; i++) begin
            plain[i]  = $urandom();
            cipher[i] = plain[i] ^ k;
            k = (k << 1) ^ (k[31] ? POLY : 32'h0);
        end
        sendSeed(32'h3C5A9E17);
        idx = 0;
        out_idx = 0;
        cycles = 0;
        while (out_idx < 1000 && cycles < 20000) begin
            bus.in_valid  = (idx < 1000) && ($urandom_range(0, 3) != 0);
            bus.in_data   = (idx < 1000) ? cipher[idx] : 32'h0;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            acc = bus.in_valid && exp_in_ready();
            if (bus.out_valid && bus.out_ready) begin
                checkOutput("s6 plaintext", bus.out_data, plain[out_idx]);
                out_idx++;
            end
            tick();
            if (acc) idx++;
            cycles++;
        end
        checkOutput("s6 words drained", out_idx, 32'd1000);

        // Asynchronous reset in the middle of a stream.
        sendSeed(32'hFFFFFFFF);
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
        applyStimulus(1'b1, 32'hCAFEF00D, 1'b1);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("s6 rst out_valid",  {31'h0, bus.out_valid}, 32'h0);
        checkOutput("s6 rst out_data",   bus.out_data,           32'h0);
        checkOutput("s6 rst in_ready",   {31'h0, bus.in_ready},  32'h0);
        checkOutput("s6 rst busy",       {31'h0, busy},          32'h0);
        checkOutput("s6 rst word_count", {16'h0, word_count},    32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 32'h12345678, 1'b1);
        applyStimulus(1'b1, 32'h12345678, 1'b1);
        checkOutput("post rst idle", {31'h0, bus.out_valid}, 32'h0);
        checkOutput("post rst count", {16'h0, word_count}, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
